// File: rtl/glyph_row_serializer_pkg.sv
// Shared text-display constants: glyph cell geometry and serializer state encoding.
// Each 8-line glyph spans 4 ROM words, with two 8-pixel rows packed per word.
package glyph_row_serializer_pkg;

  localparam int GLYPH_CELL_W    = 8;
  localparam int GLYPH_WORD_W    = 2 * GLYPH_CELL_W;
  localparam int GLYPH_LINES     = 8;
  localparam int GLYPH_WORDS     = GLYPH_LINES / 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/glyph_row_select.sv
// Picks the even-line (upper) or odd-line (lower) row out of a glyph ROM word.
// Purely combinational.
module glyph_row_select #(
  parameter int CELL_W = 8,
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_sel_odd,
  output logic [CELL_W-1:0] o_row
);

  assign o_row = i_sel_odd ? i_word[CELL_W-1:0] : i_word[WORD_W-1:CELL_W];

endmodule

// File: rtl/glyph_row_serializer.sv
// Loads one glyph row from the registered ROM word and shifts it out MSB-first.
// First pixel two clocks after cell_start; a new cell may preempt a running row.
module glyph_row_serializer
  import glyph_row_serializer_pkg::*;
#(
  parameter int CELL_W = GLYPH_CELL_W,
  parameter int WORD_W = GLYPH_WORD_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_active,
  input  logic              i_cell_start,
  input  logic              i_line_lsb,
  input  logic [WORD_W-1:0] i_glyph_data,
  input  logic              i_clr_err,
  output logic              o_pixel_on,
  output logic              o_pixel_valid,
  output logic              o_misalign_err
);

  localparam int IDX_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELL_W - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_load_pend;
  logic                w_load_pend_nxt;
  logic                r_lsb_q;
  logic                w_lsb_nxt;
  logic [CELL_W-1:0]   r_shift_reg;
  logic [CELL_W-1:0]   w_shift_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                r_misalign_err;
  logic                w_err_nxt;
  logic                w_set_err;
  logic [CELL_W-1:0]   w_row;

  // lsb_q is the registered copy so a fresh cell_start this cycle cannot
  // steer the row being loaded from the previous fetch.
  glyph_row_select #(
    .CELL_W (CELL_W),
    .WORD_W (WORD_W)
  ) u_row_select (
    .i_word    (i_glyph_data),
    .i_sel_odd (r_lsb_q),
    .o_row     (w_row)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_load_pend    <= 1'b0;
      r_lsb_q        <= 1'b0;
      r_shift_reg    <= '0;
      r_idx          <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_load_pend    <= w_load_pend_nxt;
      r_lsb_q        <= w_lsb_nxt;
      r_shift_reg    <= w_shift_nxt;
      r_idx          <= w_idx_nxt;
      r_misalign_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_pend_nxt = r_load_pend;
    w_lsb_nxt       = r_lsb_q;
    w_shift_nxt     = r_shift_reg;
    w_idx_nxt       = r_idx;
    w_set_err       = 1'b0;

    if (!i_active) begin
      w_state_nxt     = IDLE;
      w_load_pend_nxt = 1'b0;
      w_shift_nxt     = '0;
    end else begin
      if (r_load_pend) begin
        w_shift_nxt     = w_row;
        w_idx_nxt       = '0;
        w_state_nxt     = SHIFT;
        w_load_pend_nxt = 1'b0;
        w_set_err       = (r_state == SHIFT) && (r_idx != IDX_LAST);
      end else if (r_state == SHIFT) begin
        if (r_idx != IDX_LAST) begin
          w_shift_nxt = r_shift_reg << 1;
          w_idx_nxt   = r_idx + 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_shift_nxt = '0;
        end
      end

      // A cell_start coinciding with a load keeps the fetch pipeline primed.
      if (i_cell_start) begin
        w_load_pend_nxt = 1'b1;
        w_lsb_nxt       = i_line_lsb;
      end
    end

    if (w_set_err) begin
      w_err_nxt = 1'b1;
    end else if (i_clr_err) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_misalign_err;
    end
  end

  assign o_pixel_on     = r_shift_reg[CELL_W-1];
  assign o_pixel_valid  = (r_state == SHIFT);
  assign o_misalign_err = r_misalign_err;

endmodule
